muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and HI/LO width; only 32 is required to be supported.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, requesting an operation from the control unit.
REQ-005 The block SHALL have port op, input, 1 bit, selecting the operation: 0 = signed mult, 1 = signed div.
REQ-006 The block SHALL have port a, input, WIDTH bits, the rs operand and dividend.
REQ-007 The block SHALL have port b, input, WIDTH bits, the rt operand and divisor.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-010 The block SHALL have port div_zero, output, 1 bit, a one-cycle pulse coincident with done on divide-by-zero.
REQ-011 The block SHALL have port hi, output, WIDTH bits, the HI result register.
REQ-012 The block SHALL have port lo, output, WIDTH bits, the LO result register.

Function
REQ-013 The FSM SHALL have four states: IDLE, CALC, FIX and DONE; busy SHALL be high in every state except IDLE, and done SHALL be high only in DONE.
REQ-014 In IDLE with start=1, the block SHALL latch a, b and op, and record the operand signs, on the same edge.
REQ-015 On that edge the FSM SHALL enter CALC with a 5-bit cycle counter cleared to 0, except in the divide-by-zero case (REQ-020).
REQ-016 In CALC, the block SHALL perform one iteration per cycle on the operand magnitudes:
- mult: shift-add;
- div: restoring shift-subtract.
It SHALL stay in CALC for exactly 32 cycles, counter 0..31, then enter FIX.
REQ-017 In FIX, the block SHALL apply sign correction for one cycle, then enter DONE, loading hi/lo on that edge.
REQ-018 Mult result rule: the 64-bit two's-complement product of signed a*b; hi = bits 63:32, lo = bits 31:0.
REQ-019 Div result rule:
- lo = quotient, truncated toward zero;
- hi = remainder, with the sign of the dividend and |hi| < |b|.
REQ-020 Divide by zero (op=1, b=0 at the accepting edge): the FSM SHALL go directly IDLE->DONE with div_zero set; no CALC or FIX; hi/lo unchanged.
REQ-021 Latency: when start is accepted at edge N, done SHALL be high in the cycle following edge N+33, or following edge N for divide-by-zero.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE; a start present in the DONE cycle SHALL be ignored.
REQ-023 start SHALL be ignored in CALC, FIX and DONE; no queuing.
REQ-024 Changes on a, b or op while busy SHALL NOT affect the result in progress.
REQ-025 hi/lo SHALL change only on the edge entering DONE for a non-zero-divisor operation, and SHALL hold between operations.
REQ-026 div_zero SHALL be low whenever done is low.
REQ-027 Overflow case 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0, with no exception flag.

Reset
REQ-028 When reset=1 at an edge, the block SHALL:
- enter IDLE;
- clear the counter and internal operand/accumulator registers;
- set hi=0, lo=0, busy=0, done=0, div_zero=0.
REQ-029 Reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-030 After reset deasserts, a start on the next edge SHALL be accepted normally.

Verification
REQ-031 Mult: op=0, a=7, b=0xFFFFFFFD (-3) -> done 33 cycles after the accepting edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 34 cycles.
REQ-032 Div: op=1, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-033 Div by zero: after REQ-031, op=1, a=5, b=0 -> done=1 and div_zero=1 in the next cycle only; hi/lo keep 0xFFFFFFFF/0xFFFFFFEB; busy high 1 cycle.
REQ-034 Extremes:
- mult 0x80000000*0x80000000 -> hi=0x40000000, lo=0;
- div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 Mid-operation behaviour:
- start=1 with changed a/b asserted during CALC -> ignored, original result delivered;
- reset at CALC cycle 10 -> next cycle busy=0, hi=lo=0, no done through 40 further cycles.

Source files
------------

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential signed 32x32 multiply / 32/32 divide unit with HI/LO results
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes, sign fixed at the end.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateType;

  localparam logic [4:0] lastCount = 5'(WIDTH - 1);

  stateType state, nextState;

  logic               opReg;
  logic               signA;
  logic               signB;
  logic               divZeroReg;
  logic [4:0]         count;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic               isDivZero;
  logic [WIDTH:0]     addSum;
  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] iterNext;
  logic [2*WIDTH-1:0] negAcc;
  logic [WIDTH-1:0]   negRem;
  logic [WIDTH-1:0]   negQuo;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    div_zero  = (state == DONE) && divZeroReg;
    case (state)
      IDLE:    if (start) nextState = isDivZero ? DONE : CALC;
      CALC:    if (count == lastCount) nextState = FIX;
      FIX:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    absA      = a[WIDTH-1] ? -a : a;
    absB      = b[WIDTH-1] ? -b : b;
    isDivZero = op && (b == '0);

    // Multiply: acc = {partial, multiplier}; add on LSB then shift right.
    addSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magB} : '0);

    // Divide: acc = {remainder, dividend/quotient}; shift left, keep the subtract if it didn't borrow.
    shifted = {acc[2*WIDTH-2:0], 1'b0};
    diff    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, magB};

    if (opReg) begin
      iterNext = diff[WIDTH] ? shifted : {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end else begin
      iterNext = {addSum, acc[WIDTH-1:1]};
    end

    negAcc = -acc;
    negRem = -acc[2*WIDTH-1:WIDTH];
    negQuo = -acc[WIDTH-1:0];
    if (opReg) begin
      fixHi = signA ? negRem : acc[2*WIDTH-1:WIDTH];
      fixLo = (signA ^ signB) ? negQuo : acc[WIDTH-1:0];
    end else begin
      {fixHi, fixLo} = (signA ^ signB) ? negAcc : acc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opReg      <= 1'b0;
      signA      <= 1'b0;
      signB      <= 1'b0;
      divZeroReg <= 1'b0;
      count      <= '0;
      magB       <= '0;
      acc        <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opReg      <= op;
            signA      <= a[WIDTH-1];
            signB      <= b[WIDTH-1];
            divZeroReg <= isDivZero;
            magB       <= absB;
            acc        <= {{WIDTH{1'b0}}, absA};
            count      <= '0;
          end
        end
        CALC: begin
          acc   <= iterNext;
          count <= count + 5'd1;
        end
        FIX: begin
          hi <= fixHi;
          lo <= fixLo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed table-driven bench for muldiv_seq
module tb_muldiv_seq;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
    logic        perturb;
  } vecType;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] prevHi = '0;
  logic [31:0] prevLo = '0;
  vecType vecs [14];

  muldiv_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; watches 40 cycles after the accepting edge.
  task automatic runOp(input int idx, input vecType v);
    int doneAt = -1;
    int busyCnt = 0, doneCnt = 0, dzCnt = 0, strayDz = 0, holdBad = 0;
    string tag;
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == 0) start = 1'b0;
      if (v.perturb && k == 5) begin
        start = 1'b1; a = ~v.a; b = v.b + 32'd3; op = ~v.op;
      end
      if (v.perturb && k == 6) start = 1'b0;
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
      end
      if (div_zero) dzCnt++;
      if (div_zero && !done) strayDz++;
      if (!done && doneAt < 0 && (hi !== prevHi || lo !== prevLo)) holdBad++;
    end
    tag = $sformatf("v%0d", idx);
    check({tag, " latency"}, 32'(doneAt), v.expDz ? 32'd0 : 32'd33);
    check({tag, " busy cycles"}, 32'(busyCnt), v.expDz ? 32'd1 : 32'd34);
    check({tag, " done pulses"}, 32'(doneCnt), 32'd1);
    check({tag, " div_zero pulses"}, 32'(dzCnt), v.expDz ? 32'd1 : 32'd0);
    check({tag, " div_zero without done"}, 32'(strayDz), 32'd0);
    check({tag, " hi/lo held while busy"}, 32'(holdBad), 32'd0);
    check({tag, " hi"}, hi, v.expHi);
    check({tag, " lo"}, lo, v.expLo);
    prevHi = v.expHi;
    prevLo = v.expLo;
  endtask

  initial begin
    int doneSeen;
    vecType mulVec;

    //          op  a             b             expHi         expLo         dz  perturb
    vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'd7,        32'd100,      32'h00000007, 32'h00000000, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000007, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b0};

    repeat (3) @(negedge clock);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 14; i++) runOp(i, vecs[i]);

    // Start held through the DONE cycle of a divide-by-zero must not restart.
    start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
    @(negedge clock);
    check("dz-hold done", 32'(done), 32'd1);
    check("dz-hold div_zero", 32'(div_zero), 32'd1);
    @(negedge clock);
    check("start in DONE ignored busy", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clock);
    check("start in DONE ignored busy2", 32'(busy), 32'd0);
    check("dz-hold hi", hi, prevHi);
    check("dz-hold lo", lo, prevLo);

    // Reset during CALC cycle 10 aborts with no done pulse.
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clock);
      if (k == 0) start = 1'b0;
      if (k == 10) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    doneSeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done || busy) doneSeen++;
    end
    check("abort no done/busy", 32'(doneSeen), 32'd0);
    prevHi = '0;
    prevLo = '0;

    // Start on the first edge after reset releases.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mulVec = vecs[0];
    runOp(99, mulVec);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
